// File: rtl/inst_enc_loader.sv
// Packs decoded RV32I fields into machine words and writes them sequentially into instruction memory.
// Optional immediate range checking is enabled by defining INST_ENC_CHECK_EN.
module inst_enc_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count
);

    localparam logic [2:0] FmtR = 3'd0;
    localparam logic [2:0] FmtI = 3'd1;
    localparam logic [2:0] FmtS = 3'd2;
    localparam logic [2:0] FmtB = 3'd3;
    localparam logic [2:0] FmtU = 3'd4;
    localparam logic [2:0] FmtJ = 3'd5;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       enc_word;
    logic              fmt_ok;
    logic              range_ok;

    always_comb begin
        enc_word = 32'h0;
        fmt_ok   = 1'b1;
        case (fmt)
            FmtR: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FmtI: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            FmtS: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FmtB: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FmtU: enc_word = {imm[31:12], rd, opcode};
            FmtJ: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: fmt_ok = 1'b0;
        endcase
    end

`ifdef INST_ENC_CHECK_EN
    // Immediate must survive the truncation of its format unchanged.
    always_comb begin
        range_ok = 1'b1;
        case (fmt)
            FmtI, FmtS: range_ok = (imm[31:11] == {21{imm[11]}});
            FmtB:       range_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
            FmtJ:       range_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
            FmtU:       range_ok = (imm[11:0] == 12'h0);
            default:    range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    ptr_d   = {base_addr[ADDR_W-1:2], 2'b00};
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    if (fmt_ok && range_ok) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + ADDR_W'(4);
                        count_d = count_q + ADDR_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready  = (state_q == StLoad);
    assign busy      = (state_q == StLoad) || (state_q == StDone);
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign count     = count_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_inst_enc_loader.sv
// Directed bench for inst_enc_loader: a 10-bit-address instance for encoding and session behaviour,
// plus a 4-bit-address instance for pointer wrap, ignored start and mid-session reset.
module tb_inst_enc_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Shared field bundle
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    // 10-bit instance
    logic        rst, start, in_valid, in_last;
    logic [9:0]  base_addr;
    logic        in_ready, mem_we, busy, done, err;
    logic [9:0]  mem_addr, count;
    logic [31:0] mem_wdata;

    // 4-bit instance
    logic        rst4, start4, valid4, last4;
    logic [3:0]  base4;
    logic        ready4, we4, busy4, done4, err4;
    logic [3:0]  addr4, count4;
    logic [31:0] wdata4;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    inst_enc_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    inst_enc_loader #(.ADDR_W(4)) dut_w4 (
        .clk(clk), .rst(rst4), .start(start4), .base_addr(base4),
        .in_valid(valid4), .in_ready(ready4), .in_last(last4),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
        .busy(busy4), .done(done4), .err(err4), .count(count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic start_session(input logic [9:0] base);
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; base_addr = '0;
        rst4 = 1'b1; start4 = 1'b0; valid4 = 1'b0; last4 = 1'b0; base4 = '0;
        set_fields(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        tick(); tick();
        rst = 1'b0; rst4 = 1'b0;

        // Reset values
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);

        // Single I-type, base 0x10
        start_session(10'h10);
        check("s1_in_ready", in_ready, 1);
        check("s1_busy", busy, 1);
        set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5);
        in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("s1_we", mem_we, 1);
        check("s1_addr", mem_addr, 32'h10);
        check("s1_wdata", mem_wdata, 32'h0050_0093);
        check("s1_done", done, 1);
        check("s1_ready_done", in_ready, 0);
        check("s1_count", count, 1);
        tick();
        check("s1_idle_busy", busy, 0);
        check("s1_idle_we", mem_we, 0);
        check("s1_idle_done", done, 0);
        check("s1_hold_addr", mem_addr, 32'h10);
        check("s1_hold_wdata", mem_wdata, 32'h0050_0093);
        check("s1_count_hold", count, 1);

        // R, S, B back-to-back from base 0
        start_session(10'h0);
        in_valid = 1'b1;
        set_fields(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h0, 32'h0);
        tick();
        check("r_we", mem_we, 1);
        check("r_addr", mem_addr, 0);
        check("r_wdata", mem_wdata, 32'h0020_81B3);
        set_fields(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0, 32'd8);
        tick();
        check("s_we", mem_we, 1);
        check("s_addr", mem_addr, 4);
        check("s_wdata", mem_wdata, 32'h0020_A423);
        set_fields(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, 32'hFFFF_FFFC);
        in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("b_we", mem_we, 1);
        check("b_addr", mem_addr, 8);
        check("b_wdata", mem_wdata, 32'hFE20_8EE3);
        check("b_done", done, 1);
        check("rsb_count", count, 3);
        tick();

        // U and J
        start_session(10'h100);
        in_valid = 1'b1;
        set_fields(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1234_5000);
        tick();
        check("u_addr", mem_addr, 32'h100);
        check("u_wdata", mem_wdata, 32'h1234_52B7);
        set_fields(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048);
        in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("j_addr", mem_addr, 32'h104);
        check("j_wdata", mem_wdata, 32'h0010_00EF);
        tick();

        // Illegal fmt between two valid bundles; unaligned base is forced aligned
        start_session(10'h23);
        in_valid = 1'b1;
        set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5);
        tick();
        check("il_first_addr", mem_addr, 32'h20);
        set_fields(3'd7, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1);
        tick();
        check("il_no_write", mem_we, 0);
        check("il_err_now", err, 1);
        set_fields(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2);
        in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("il_second_we", mem_we, 1);
        check("il_second_addr", mem_addr, 32'h24);
        check("il_second_wdata", mem_wdata, 32'h0020_0193);
        tick();
        check("il_count", count, 2);
        check("il_err_sticky", err, 1);
        start_session(10'h0);
        check("il_err_cleared", err, 0);
        check("il_count_cleared", count, 0);

        // Rejected bundle with in_last still ends session
        in_valid = 1'b1; in_last = 1'b1;
        set_fields(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("rej_last_done", done, 1);
        check("rej_last_we", mem_we, 0);
        check("rej_last_err", err, 1);
        tick();
        check("rej_last_idle", busy, 0);

        // Out-of-range I immediate
        start_session(10'h40);
        in_valid = 1'b1; in_last = 1'b1;
        set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
`ifdef INST_ENC_CHECK_EN
        check("range_we", mem_we, 0);
        check("range_err", err, 1);
`else
        check("range_we", mem_we, 1);
        check("range_wdata", mem_wdata, 32'h8000_0093);
        check("range_err", err, 0);
`endif
        tick();

        // Start during LOAD is ignored (in IDLE it is honoured)
        start_session(10'h80);
        in_valid = 1'b1; start = 1'b1; base_addr = 10'h200;
        set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5);
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("busy_start_addr", mem_addr, 32'h80);
        check("busy_start_count", count, 1);
        in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("busy_start_next_addr", mem_addr, 32'h84);
        tick();

        // 4-bit instance: wrap from 0xC to 0x0, start during LOAD ignored
        base4 = 4'hC; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("w4_ready", ready4, 1);
        valid4 = 1'b1; start4 = 1'b1; base4 = 4'h4;
        set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5);
        tick();
        start4 = 1'b0;
        check("w4_first_addr", addr4, 32'hC);
        last4 = 1'b1;
        tick();
        valid4 = 1'b0; last4 = 1'b0;
        check("w4_wrap_addr", addr4, 32'h0);
        check("w4_count", count4, 2);
        check("w4_done", done4, 1);
        tick();

        // Reset mid-session drops the pending write
        base4 = 4'h4; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        valid4 = 1'b1; rst4 = 1'b1;
        tick();
        valid4 = 1'b0; rst4 = 1'b0;
        check("w4_rst_we", we4, 0);
        check("w4_rst_busy", busy4, 0);
        check("w4_rst_addr", addr4, 0);
        check("w4_rst_wdata", wdata4, 0);
        check("w4_rst_count", count4, 0);
        check("w4_rst_ready", ready4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
